uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Frames are start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AddrW  = $clog2(FIFO_DEPTH);
  localparam int CntW   = AddrW + 1;
  localparam int TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]   DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DataLast = 3'(DATA_BITS - 1);
  localparam logic              StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AddrW-1:0]      wrPtr;
  logic [AddrW-1:0]      rdPtr;
  logic [TimerW-1:0]     bitTimer;
  logic [2:0]            bitIdx;
  logic                  stopIdx;
  logic [DATA_BITS-1:0]  shiftReg;
  logic                  parityBit;
  logic [DATA_BITS-1:0]  headData;
  logic                  bitEnd;
  logic                  frameEnd;
  logic                  wrEn;
  logic                  popEn;

  assign tx_ready = fifo_count < DepthC;
  assign wrEn     = tx_valid && tx_ready;
  assign headData = mem[rdPtr];
  assign bitEnd   = bitTimer == BitLast;
  assign frameEnd = (state == StStop) && bitEnd && (stopIdx == StopLast);
  // A pop happens either from idle or back-to-back at the end of a frame.
  assign popEn    = (fifo_count != '0) && ((state == StIdle) || frameEnd);

  always_ff @(posedge clk) begin
    if (rst_n && wrEn) begin
      mem[wrPtr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + AddrW'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + AddrW'(1);
      end
      case ({wrEn, popEn})
        2'b10:   fifo_count <= fifo_count + CntW'(1);
        2'b01:   fifo_count <= fifo_count - CntW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      bitTimer  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != StIdle) begin
        bitTimer <= bitEnd ? '0 : bitTimer + TimerW'(1);
      end
      case (state)
        StIdle: uart_tx <= 1'b1;
        StStart: begin
          if (bitEnd) begin
            state    <= StData;
            uart_tx  <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
          end
        end
        StData: begin
          if (bitEnd) begin
            if (bitIdx == DataLast) begin
              if (PARITY != 0) begin
                state   <= StParity;
                uart_tx <= parityBit;
              end else begin
                state   <= StStop;
                uart_tx <= 1'b1;
                stopIdx <= 1'b0;
              end
            end else begin
              uart_tx  <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitIdx   <= bitIdx + 3'd1;
            end
          end
        end
        StParity: begin
          if (bitEnd) begin
            state   <= StStop;
            uart_tx <= 1'b1;
            stopIdx <= 1'b0;
          end
        end
        StStop: begin
          if (frameEnd) begin
            tx_done <= 1'b1;
            state   <= StIdle;
            busy    <= 1'b0;
          end else if (bitEnd) begin
            stopIdx <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
      // Loading a new character overrides whatever the case above decided.
      if (popEn) begin
        state     <= StStart;
        uart_tx   <= 1'b0;
        busy      <= 1'b1;
        bitTimer  <= '0;
        shiftReg  <= headData;
        parityBit <= (^headData) ^ (PARITY == 1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations side by side, each checked every cycle
// against a queue of expected line/busy/done values built when characters are written.
module tb_uart_tx_fifo;

  localparam int Cpb = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      txValid;
  logic [3:0][7:0] txData;
  logic [3:0]      txReady;
  logic [3:0]      uartTx;
  logic [3:0]      busyV;
  logic [3:0]      doneV;
  logic [3:0][2:0] cnt;

  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.clk(clk), .rst_n(rst_n), .tx_data(txData[0]), .tx_valid(txValid[0]),
          .tx_ready(txReady[0]), .uart_tx(uartTx[0]), .busy(busyV[0]), .tx_done(doneV[0]),
          .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut1 (.clk(clk), .rst_n(rst_n), .tx_data(txData[1]), .tx_valid(txValid[1]),
          .tx_ready(txReady[1]), .uart_tx(uartTx[1]), .busy(busyV[1]), .tx_done(doneV[1]),
          .fifo_count(cnt[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.clk(clk), .rst_n(rst_n), .tx_data(txData[2]), .tx_valid(txValid[2]),
          .tx_ready(txReady[2]), .uart_tx(uartTx[2]), .busy(busyV[2]), .tx_done(doneV[2]),
          .fifo_count(cnt[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut3 (.clk(clk), .rst_n(rst_n), .tx_data(txData[3][6:0]), .tx_valid(txValid[3]),
          .tx_ready(txReady[3]), .uart_tx(uartTx[3]), .busy(busyV[3]), .tx_done(doneV[3]),
          .fifo_count(cnt[3]));

  typedef struct packed {
    logic line;
    logic busy;
    logic last;
  } entry_t;

  entry_t     expQ[4][$];
  logic [3:0] prevLast = '0;
  int         errors = 0;
  int         checks = 0;
  int         edges = 0;
  logic       rstAtEdge = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dataBits(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int parityMode(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int stopBits(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic pushBit(input int i, input logic v, input logic last);
    entry_t e;
    for (int k = 0; k < Cpb; k++) begin
      e.line = v;
      e.busy = 1'b1;
      e.last = last && (k == Cpb - 1);
      expQ[i].push_back(e);
    end
  endtask

  // An idle DUT starts a frame two samples after the write is driven; a DUT on its
  // last stop sample needs one idle sample; otherwise the frame follows directly.
  task automatic pushFrame(input int i, input logic [7:0] d);
    entry_t idle;
    int     ones;
    logic   p;
    idle.line = 1'b1;
    idle.busy = 1'b0;
    idle.last = 1'b0;
    while (expQ[i].size() < 2) expQ[i].push_back(idle);
    pushBit(i, 1'b0, 1'b0);
    ones = 0;
    for (int k = 0; k < dataBits(i); k++) begin
      pushBit(i, d[k], 1'b0);
      if (d[k]) ones++;
    end
    if (parityMode(i) != 0) begin
      p = (parityMode(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      pushBit(i, p, 1'b0);
    end
    for (int s = 0; s < stopBits(i); s++) pushBit(i, 1'b1, s == stopBits(i) - 1);
  endtask

  always @(posedge clk) begin
    rstAtEdge = rst_n;
    edges++;
  end

  always @(negedge clk) begin
    if (edges > 0) begin
      for (int i = 0; i < 4; i++) begin
        entry_t e;
        logic   expDone;
        e.line = 1'b1;
        e.busy = 1'b0;
        e.last = 1'b0;
        expDone = 1'b0;
        if (!rstAtEdge) begin
          expQ[i].delete();
        end else begin
          if (expQ[i].size() != 0) e = expQ[i].pop_front();
          expDone = prevLast[i];
        end
        prevLast[i] = e.last;
        checkVal($sformatf("dut%0d uart_tx", i), {31'd0, uartTx[i]}, {31'd0, e.line});
        checkVal($sformatf("dut%0d busy", i), {31'd0, busyV[i]}, {31'd0, e.busy});
        checkVal($sformatf("dut%0d tx_done", i), {31'd0, doneV[i]}, {31'd0, expDone});
      end
    end
  end

  task automatic putChar(input int i, input logic [7:0] d);
    txValid[i] = 1'b1;
    txData[i]  = d;
    pushFrame(i, d);
    @(posedge clk);
    #1;
    txValid[i] = 1'b0;
  endtask

  task automatic waitDrain(input int i, input int budget);
    int n = 0;
    while (expQ[i].size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (expQ[i].size() != 0) checkVal($sformatf("dut%0d drain timeout", i), expQ[i].size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    txValid = '0;
    txData  = '0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) checkVal($sformatf("dut%0d reset count", i), cnt[i], 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) checkVal($sformatf("dut%0d ready after reset", i), txReady[i], 1);

    // 8N1 frames with a few patterns
    putChar(0, 8'h55);
    waitDrain(0, 100);
    putChar(0, 8'hFF);
    waitDrain(0, 100);
    r = 8'($urandom_range(0, 255));
    putChar(0, r);
    putChar(0, 8'h00);
    waitDrain(0, 200);

    // even and odd parity on the same character
    putChar(1, 8'h07);
    putChar(2, 8'h07);
    waitDrain(1, 100);
    waitDrain(2, 100);

    // 7 data bits, 2 stop bits
    putChar(3, 8'h41);
    r = 8'($urandom_range(0, 127));
    putChar(3, r);
    waitDrain(3, 200);

    // burst of five from idle fills the FIFO
    for (int v = 1; v <= 5; v++) begin
      txValid[0] = 1'b1;
      txData[0]  = 8'(v);
      pushFrame(0, 8'(v));
      @(posedge clk);
      #1;
    end
    txValid[0] = 1'b0;
    checkVal("burst count", cnt[0], 4);
    checkVal("burst ready", txReady[0], 0);

    // hold a write across the frame-end pop while full
    repeat (36) @(posedge clk);
    #1;
    txValid[0] = 1'b1;
    txData[0]  = 8'h06;
    @(posedge clk);
    #1;
    checkVal("full pop count", cnt[0], 3);
    checkVal("full pop ready", txReady[0], 1);
    pushFrame(0, 8'h06);
    @(posedge clk);
    #1;
    checkVal("refill count", cnt[0], 4);
    txValid[0] = 1'b0;
    waitDrain(0, 400);

    // reset in the middle of data bit 3 with more characters queued
    for (int v = 0; v < 3; v++) begin
      txValid[0] = 1'b1;
      txData[0]  = (v == 0) ? 8'hA5 : (v == 1) ? 8'h3C : 8'h81;
      pushFrame(0, txData[0]);
      @(posedge clk);
      #1;
    end
    txValid[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n      = 1'b0;
    txValid[1] = 1'b1;
    txData[1]  = 8'h99;
    @(posedge clk);
    #1;
    checkVal("abort uart_tx", uartTx[0], 1);
    checkVal("abort busy", busyV[0], 0);
    checkVal("abort count", cnt[0], 0);
    rst_n      = 1'b1;
    txValid[1] = 1'b0;
    checkVal("write during reset", cnt[1], 0);
    @(posedge clk);
    #1;
    checkVal("ready after abort", txReady[0], 1);
    repeat (60) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
